p2s_rr_arbiter: RTL
===================

// Module: p2s_rr_arbiter
// PURPOSE
//   Round-robin arbiter sharing one parallel-to-serial serializer between N_REQ word sources.
//   Sits upstream of the Par2Ser stage: s_* ports face the sources, m_* ports drive the serializer's
//   din/din_vld and take its dout_rdy. Grants one source for a burst of up to BURST_LEN words, then rotates.
// PARAMETERS
//   N_REQ      4   number of requesters (>=2; need not be a power of two)
//   WIDTH      8   word width, equal to the serializer WIDTH
//   BURST_LEN  4   max words accepted per grant (>=1)
// PORTS
//   clk      in   1              clock; all state on rising edge
//   rst_n    in   1              reset, synchronous, active-low
//   s_din    in   N_REQ*WIDTH    requester words; requester i at [i*WIDTH +: WIDTH]
//   s_vld    in   N_REQ          requester valid, one bit per requester
//   s_rdy    out  N_REQ          requester ready, one-hot or zero
//   m_din    out  WIDTH          word to serializer din
//   m_vld    out  1              to serializer din_vld
//   m_rdy    in   1              from serializer dout_rdy
//   gnt_id   out  $clog2(N_REQ)  index of current or most recent grant
//   busy     out  1              1 while in GRANT
// BEHAVIOUR
//   - rst_n low at a clock edge: state=IDLE, gnt_id=0, rr pointer ptr=0, burst count bcnt=0.
//     Outputs after reset: busy=0, m_vld=0, s_rdy=0, m_din=s_din slice 0. Holds mid-burst; the partial burst is dropped.
//   - FSM IDLE: if any s_vld, pick the first set bit scanning ptr, ptr+1, .. N_REQ-1, 0, ..
//     (mod N_REQ); register gnt_id; bcnt=0; next state GRANT. If no s_vld, stay in IDLE.
//   - FSM GRANT (busy=1), combinational path, zero latency:
//     m_din=s_din[gnt_id], m_vld=s_vld[gnt_id], s_rdy[gnt_id]=m_rdy, other s_rdy bits=0.
//   - Handshake hs = s_vld[gnt_id] & m_rdy; hs increments bcnt.
//   - GRANT exits to IDLE with ptr=(gnt_id+1) mod N_REQ when either:
//     hs & bcnt==BURST_LEN-1 (burst done; the last word is still accepted in that cycle), or
//     s_vld[gnt_id]==0 (source idle, release; no word transferred).
//   - Each grant costs exactly one IDLE cycle (m_vld=0, s_rdy=0). Grant latency: 1 clk from s_vld to s_rdy/m_vld.
//   - m_rdy low holds the grant indefinitely; bcnt, gnt_id and ptr are frozen.
//   - Pointer wrap: gnt_id=N_REQ-1 gives ptr=0. BURST_LEN=1 gives one word per grant.
//   - gnt_id keeps its value in IDLE. s_rdy is never asserted for a non-granted requester.
//   - bcnt width: $clog2(BURST_LEN+1).
//   - Requesters follow valid/ready rules: once s_vld is high, s_din is stable until hs.
// CONFIGURATION
//   P2S_ARB_CNT_EN defined: adds an output port word_cnt [15:0].
//     - word_cnt reset value is 0 (synchronous).
//     - Increments by 1 on every hs and wraps from 0xFFFF to 0x0000.
//   P2S_ARB_CNT_EN undefined: the port and the counter are absent. All other behaviour is identical.
// TESTING
//   1 Reset: rst_n=0 for 3 clk with all s_vld=1 -> s_rdy=0, m_vld=0, busy=0, gnt_id=0.
//   2 Rotation: s_vld=4'b1111, m_rdy=1, BURST_LEN=4 -> grants 0,1,2,3,0.
//     Each grant = 4 consecutive hs, then 1 idle cycle.
//   3 Release: only req2 valid; it drops s_vld after 2 words -> back to IDLE, ptr=3.
//     Next request from req0 is granted after 1 clk.
//   4 Backpressure: m_rdy=0 for 5 clk mid-burst -> gnt_id, bcnt, m_din stable.
//     Burst resumes and completes at 4 words.
//   5 Skip/wrap: s_vld=4'b1001, last grant 0 -> next grant 3, then 0. s_rdy is always one-hot or 0.
//   6 Mid-burst reset: assert rst_n=0 after word 2 -> next cycle IDLE, ptr=0.
//     With P2S_ARB_CNT_EN defined, word_cnt=0; without it, the port is absent.

Source files
------------

// File: rtl/p2s_rr_arbiter.sv
// Round-robin arbiter sharing one parallel-to-serial serializer between N_REQ word sources.
// Optional feature: define P2S_ARB_CNT_EN to add the 16-bit word_cnt handshake counter output.
module p2s_rr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ*WIDTH-1:0]   s_din,
    input  logic [N_REQ-1:0]         s_vld,
    output logic [N_REQ-1:0]         s_rdy,
    output logic [WIDTH-1:0]         m_din,
    output logic                     m_vld,
    input  logic                     m_rdy,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     busy
`ifdef P2S_ARB_CNT_EN
    ,
    output logic [15:0]              word_cnt
`endif
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     ptr, ptr_nxt, gnt_nxt, pick, off, gnt_inc;
    logic [CW-1:0]     bcnt, bcnt_nxt;
    logic [2*N_REQ-1:0] vld2;
    logic [N_REQ-1:0]  rot;
    logic [IW:0]       sum;
    logic              gvld, hs, last;

    logic [N_REQ-1:0][WIDTH-1:0] din_arr;
    assign din_arr = s_din;

    assign busy  = (state == GRANT);
    assign gvld  = s_vld[gnt_id];
    assign hs    = busy & gvld & m_rdy;
    assign last  = (bcnt == CW'(BURST_LEN - 1));
    assign m_din = din_arr[gnt_id];
    assign m_vld = busy & gvld;

    genvar i;
    generate
        for (i = 0; i < N_REQ; i++) begin : g_rdy
            assign s_rdy[i] = busy & m_rdy & (gnt_id == IW'(i));
        end
    endgenerate

    // Rotate valids so bit 0 is the requester at ptr; lowest set bit is the winner offset.
    always_comb begin
        vld2 = {s_vld, s_vld} >> ptr;
        rot  = vld2[N_REQ-1:0];
        off  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = IW'(k);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
        pick = sum[IW-1:0];
    end

    assign gnt_inc = (gnt_id == IW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_id;
        ptr_nxt   = ptr;
        bcnt_nxt  = bcnt;
        case (state)
            IDLE: begin
                if (|s_vld) begin
                    state_nxt = GRANT;
                    gnt_nxt   = pick;
                    bcnt_nxt  = '0;
                end
            end
            GRANT: begin
                if (!gvld) begin
                    state_nxt = IDLE;
                    ptr_nxt   = gnt_inc;
                    bcnt_nxt  = '0;
                end else if (m_rdy) begin
                    if (last) begin
                        state_nxt = IDLE;
                        ptr_nxt   = gnt_inc;
                        bcnt_nxt  = '0;
                    end else begin
                        bcnt_nxt  = bcnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            gnt_id <= '0;
            ptr    <= '0;
            bcnt   <= '0;
        end else begin
            state  <= state_nxt;
            gnt_id <= gnt_nxt;
            ptr    <= ptr_nxt;
            bcnt   <= bcnt_nxt;
        end
    end

`ifdef P2S_ARB_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)  word_cnt <= '0;
        else if (hs) word_cnt <= word_cnt + 16'd1;
    end
`endif

endmodule
